// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer for an external up/down counter: loads a start value, steps toward
// an end value every D+1 cycles, optionally sweeps back, then pulses done.
module counter_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             cmd_bounce,
    input  logic             abort,
    output logic             ctr_set,
    output logic [WIDTH-1:0] ctr_set_value,
    output logic             ctr_enable,
    output logic             ctr_up_down,
    input  logic [WIDTH-1:0] ctr_count,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic             bounce_q, bounce_d;
    logic             dir_q, dir_d;
    logic             phase_q, phase_d;
    logic             aborted_q, aborted_d;

    logic [WIDTH-1:0] target;
    logic             cur_dir;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_q   <= '0;
            end_q     <= '0;
            div_q     <= '0;
            presc_q   <= '0;
            bounce_q  <= 1'b0;
            dir_q     <= 1'b0;
            phase_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            end_q     <= end_d;
            div_q     <= div_d;
            presc_q   <= presc_d;
            bounce_q  <= bounce_d;
            dir_q     <= dir_d;
            phase_q   <= phase_d;
            aborted_q <= aborted_d;
        end
    end

    // Phase 1 is the return leg of a bounce: aim back at start, opposite direction.
    assign target  = phase_q ? start_q : end_q;
    assign cur_dir = phase_q ? ~dir_q : dir_q;

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        end_d         = end_q;
        div_d         = div_q;
        presc_d       = presc_q;
        bounce_d      = bounce_q;
        dir_d         = dir_q;
        phase_d       = phase_q;
        aborted_d     = 1'b0;
        cmd_ready     = 1'b0;
        ctr_set       = 1'b0;
        ctr_set_value = '0;
        ctr_enable    = 1'b0;
        done          = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    start_d  = cmd_start;
                    end_d    = cmd_end;
                    div_d    = cmd_div;
                    bounce_d = cmd_bounce;
                    dir_d    = (cmd_end > cmd_start);
                    phase_d  = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                ctr_set       = 1'b1;
                ctr_set_value = start_q;
                presc_d       = div_q;
                state_d       = S_SETTLE;
            end
            S_SETTLE: begin
                presc_d = div_q;
                state_d = S_RUN;
            end
            S_RUN: begin
                // Arrival is checked against the live count so D=0 cannot overshoot.
                if (ctr_count != target) begin
                    if (presc_q == '0) begin
                        ctr_enable = 1'b1;
                        presc_d    = div_q;
                    end else begin
                        presc_d = presc_q - DIV_W'(1);
                    end
                end else if (!phase_q && bounce_q && (start_q != end_q)) begin
                    phase_d = 1'b1;
                    presc_d = div_q;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A completing command is left alone; abort only cancels LOAD/SETTLE/RUN.
        if (abort && (state_q != S_IDLE) && (state_q != S_DONE)) begin
            ctr_set    = 1'b0;
            ctr_enable = 1'b0;
            state_d    = S_IDLE;
            aborted_d  = 1'b1;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign ctr_up_down = busy ? cur_dir : 1'b0;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: a behavioural 4-bit counter closes the loop, and
// directed plus randomized commands are checked against a closed-form timing model.
module tb_counter_sweep_ctrl;
    localparam int WIDTH = 4;
    localparam int DIV_W = 8;
    localparam int MAXC  = 8192;

    logic             clk = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_start;
    logic [WIDTH-1:0] cmd_end;
    logic [DIV_W-1:0] cmd_div;
    logic             cmd_bounce;
    logic             abort;
    logic             ctr_set;
    logic [WIDTH-1:0] ctr_set_value;
    logic             ctr_enable;
    logic             ctr_up_down;
    logic [WIDTH-1:0] ctr_count;
    logic             busy;
    logic             done;
    logic             aborted;

    logic [WIDTH-1:0] cnt_q = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic             tr_set  [MAXC];
    logic [WIDTH-1:0] tr_sv   [MAXC];
    logic             tr_en   [MAXC];
    logic             tr_ud   [MAXC];
    logic             tr_busy [MAXC];
    logic             tr_rdy  [MAXC];
    logic             tr_done [MAXC];
    logic             tr_ab   [MAXC];
    logic [WIDTH-1:0] tr_cnt  [MAXC];

    // closed-form model state for one command
    int m_s, m_e, m_d, m_n, m_t1, m_done, m_a, m_endc;
    bit m_b, m_dir, m_abe;

    always #5 clk = ~clk;

    // the external counter this block drives
    always @(posedge clk) begin
        if (ctr_set) cnt_q <= ctr_set_value;
        else if (ctr_enable) cnt_q <= ctr_up_down ? cnt_q + 4'd1 : cnt_q - 4'd1;
    end
    assign ctr_count = cnt_q;

    counter_sweep_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_end(cmd_end), .cmd_div(cmd_div),
        .cmd_bounce(cmd_bounce), .abort(abort), .ctr_set(ctr_set),
        .ctr_set_value(ctr_set_value), .ctr_enable(ctr_enable),
        .ctr_up_down(ctr_up_down), .ctr_count(ctr_count), .busy(busy),
        .done(done), .aborted(aborted)
    );

    // Cycle 0 is the offer cycle; cmd_valid stays high through valid_until.
    task automatic run_cmd(input int s, input int e, input int d, input bit b,
                           input int abort_cyc, input int valid_until, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            cmd_valid  = (c <= valid_until);
            cmd_start  = WIDTH'(s);
            cmd_end    = WIDTH'(e);
            cmd_div    = DIV_W'(d);
            cmd_bounce = b;
            abort      = (c == abort_cyc);
            #2;
            tr_set[c]  = ctr_set;
            tr_sv[c]   = ctr_set_value;
            tr_en[c]   = ctr_enable;
            tr_ud[c]   = ctr_up_down;
            tr_busy[c] = busy;
            tr_rdy[c]  = cmd_ready;
            tr_done[c] = done;
            tr_ab[c]   = aborted;
            tr_cnt[c]  = ctr_count;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic model_set(input int s, input int e, input int d, input bit b, input int a);
        m_s = s; m_e = e; m_d = d; m_b = b; m_a = a;
        m_n    = (s > e) ? s - e : e - s;
        m_dir  = (e > s);
        m_t1   = m_n * (d + 1);
        m_done = (m_n == 0) ? 4 : (b ? 2 * m_t1 + 5 : m_t1 + 4);
        m_abe  = (a >= 1) && (a < m_done);
        m_endc = m_abe ? a : m_done;
    endtask

    function automatic bit m_busy(int c);
        return (c >= 1) && (c <= m_endc);
    endfunction

    function automatic bit m_phase1(int c);
        return m_b && (m_n > 0) && (c >= 4 + m_t1);
    endfunction

    function automatic bit m_en(int c);
        int r;
        if (m_n == 0 || !m_busy(c)) return 1'b0;
        if (m_abe && c >= m_a) return 1'b0;
        r = m_phase1(c) ? c - (4 + m_t1) : c - 3;
        return (r >= 0) && (r < m_t1) && (((r + 1) % (m_d + 1)) == 0);
    endfunction

    function automatic logic [6:0] m_vec(int c);
        bit set_e, ud_e;
        set_e = (c == 1) && !(m_abe && m_a == 1);
        ud_e  = m_busy(c) ? (m_phase1(c) ? !m_dir : m_dir) : 1'b0;
        return {set_e, m_en(c), ud_e, m_busy(c), !m_busy(c),
                (c == m_done) && !m_abe, m_abe && (c == m_a + 1)};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b1; cmd_start = 4'd1; cmd_end = 4'd9;
        cmd_div = 8'd0; cmd_bounce = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        n_tests++;
        if ({cmd_ready, busy, ctr_set, ctr_enable, done, aborted, ctr_up_down} !== 7'b1000000
            || ctr_set_value !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy/busy/set/en/done/ab/ud=%b sv=%0d want 1000000 sv=0",
                     {cmd_ready, busy, ctr_set, ctr_enable, done, aborted, ctr_up_down}, ctr_set_value);
        end
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0;
        @(negedge clk);
        #2;
        n_tests++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_no_accept: got busy=%b rdy=%b want busy=0 rdy=1", busy, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_run;
        run_cmd(0, 15, 3, 1'b0, -1, 0, 6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #2;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0 || ctr_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: got busy=%b done=%b ab=%b en=%b want all 0",
                     busy, done, aborted, ctr_enable);
        end
    endtask

    task automatic test_up_sweep;
        int bad;
        run_cmd(2, 6, 0, 1'b0, -1, 0, 12);
        n_tests++;
        if (tr_set[1] !== 1'b1 || tr_sv[1] !== 4'd2) begin
            n_fail++;
            $display("FAIL up_load: got set=%b sv=%0d want set=1 sv=2", tr_set[1], tr_sv[1]);
        end
        bad = -1;
        for (int c = 0; c < 12; c++)
            if (tr_en[c] !== (c >= 3 && c <= 6) && bad < 0) bad = c;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL up_enables: cycle %0d got en=%b want %b", bad, tr_en[bad], (bad >= 3 && bad <= 6));
        end
        n_tests++;
        if (tr_cnt[7] !== 4'd6 || tr_ud[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL up_count: got count=%0d ud=%b want count=6 ud=1", tr_cnt[7], tr_ud[4]);
        end
        n_tests++;
        if (tr_done[8] !== 1'b1 || tr_done[7] !== 1'b0 || tr_rdy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL up_done: got done7=%b done8=%b rdy9=%b want 0 1 1", tr_done[7], tr_done[8], tr_rdy[9]);
        end
    endtask

    task automatic test_bounce_down;
        int bad, lo, hi;
        run_cmd(9, 7, 2, 1'b1, -1, 0, 20);
        n_tests++;
        if (tr_ud[3] !== 1'b0 || tr_ud[12] !== 1'b1) begin
            n_fail++;
            $display("FAIL bounce_dir: got ud3=%b ud12=%b want 0 1", tr_ud[3], tr_ud[12]);
        end
        bad = -1;
        for (int c = 0; c < 20; c++)
            if (tr_en[c] !== (c == 5 || c == 8 || c == 12 || c == 15) && bad < 0) bad = c;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL bounce_enables: cycle %0d got en=%b", bad, tr_en[bad]);
        end
        lo = 15; hi = 0;
        for (int c = 2; c <= 17; c++) begin
            if (int'(tr_cnt[c]) < lo) lo = int'(tr_cnt[c]);
            if (int'(tr_cnt[c]) > hi) hi = int'(tr_cnt[c]);
        end
        n_tests++;
        if (lo != 7 || hi != 9 || tr_cnt[9] !== 4'd7 || tr_cnt[17] !== 4'd9) begin
            n_fail++;
            $display("FAIL bounce_counts: got min=%0d max=%0d c9=%0d c17=%0d want 7 9 7 9",
                     lo, hi, tr_cnt[9], tr_cnt[17]);
        end
        n_tests++;
        if (tr_done[17] !== 1'b1 || tr_done[16] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_done: got done16=%b done17=%b want 0 1", tr_done[16], tr_done[17]);
        end
    endtask

    task automatic test_equal;
        int ens;
        run_cmd(5, 5, 4, 1'b1, -1, 0, 8);
        ens = 0;
        for (int c = 0; c < 8; c++) if (tr_en[c] === 1'b1) ens++;
        n_tests++;
        if (ens != 0 || tr_done[4] !== 1'b1 || tr_rdy[5] !== 1'b1 || tr_busy[4] !== 1'b1) begin
            n_fail++;
            $display("FAIL equal_endpoints: got enables=%0d done4=%b rdy5=%b busy4=%b want 0 1 1 1",
                     ens, tr_done[4], tr_rdy[5], tr_busy[4]);
        end
    endtask

    task automatic test_abort;
        int dn;
        run_cmd(0, 15, 1, 1'b0, 8, 0, 14);
        n_tests++;
        if (tr_en[6] !== 1'b1 || tr_en[8] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_gate: got en6=%b en8=%b want 1 0", tr_en[6], tr_en[8]);
        end
        dn = 0;
        for (int c = 0; c < 14; c++) if (tr_done[c] === 1'b1) dn++;
        n_tests++;
        if (tr_ab[8] !== 1'b0 || tr_ab[9] !== 1'b1 || tr_ab[10] !== 1'b0 || dn != 0 || tr_rdy[9] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pulse: got ab8/9/10=%b%b%b dones=%0d rdy9=%b want 010 0 1",
                     tr_ab[8], tr_ab[9], tr_ab[10], dn, tr_rdy[9]);
        end
        n_tests++;
        if (tr_cnt[9] !== 4'd2) begin
            n_fail++;
            $display("FAIL abort_count: got %0d want 2", tr_cnt[9]);
        end
    endtask

    task automatic test_extreme;
        int ens, badgap;
        run_cmd(0, 15, 255, 1'b0, -1, 0, 3847);
        ens = 0; badgap = -1;
        for (int c = 0; c < 3847; c++)
            if (tr_en[c] === 1'b1) begin
                ens++;
                if ((c < 258 || ((c - 258) % 256) != 0) && badgap < 0) badgap = c;
            end
        n_tests++;
        if (ens != 15 || badgap >= 0) begin
            n_fail++;
            $display("FAIL extreme_enables: got %0d enables, off-grid at %0d, want 15 on grid", ens, badgap);
        end
        n_tests++;
        if (tr_done[3844] !== 1'b1 || tr_done[3843] !== 1'b0 || tr_cnt[3844] !== 4'd15) begin
            n_fail++;
            $display("FAIL extreme_done: got done3843=%b done3844=%b count=%0d want 0 1 15",
                     tr_done[3843], tr_done[3844], tr_cnt[3844]);
        end
    endtask

    task automatic test_back_to_back;
        int bad;
        run_cmd(3, 5, 1, 1'b0, -1, 9, 20);
        bad = -1;
        for (int c = 0; c < 20; c++)
            if (tr_set[c] !== (c == 1 || c == 10) && bad < 0) bad = c;
        n_tests++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL b2b_accept: cycle %0d got set=%b", bad, tr_set[bad]);
        end
        n_tests++;
        if (tr_done[8] !== 1'b1 || tr_rdy[9] !== 1'b1 || tr_busy[10] !== 1'b1 || tr_done[17] !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_timing: got done8=%b rdy9=%b busy10=%b done17=%b want 1 1 1 1",
                     tr_done[8], tr_rdy[9], tr_busy[10], tr_done[17]);
        end
    endtask

    task automatic test_random_sweeps;
        int s, e, d, a, bad, lo, hi;
        bit b;
        logic [6:0] act, exp_v;
        for (int it = 0; it < 24; it++) begin
            s = $urandom_range(0, 15);
            e = (it % 4 == 0) ? s : $urandom_range(0, 15);
            d = $urandom_range(0, 7);
            b = 1'($urandom_range(0, 1));
            model_set(s, e, d, b, -1);
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, m_done + 1) : -1;
            model_set(s, e, d, b, a);
            run_cmd(s, e, d, b, a, 0, m_endc + 3);
            bad = -1;
            for (int c = 0; c < m_endc + 3; c++) begin
                act = {tr_set[c], tr_en[c], tr_ud[c], tr_busy[c], tr_rdy[c], tr_done[c], tr_ab[c]};
                exp_v = m_vec(c);
                if ((act !== exp_v || tr_sv[c] !== ((c == 1) ? WIDTH'(s) : WIDTH'(0))) && bad < 0) bad = c;
            end
            n_tests++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL rand%0d_trace s=%0d e=%0d d=%0d b=%0d a=%0d cycle %0d: got set/en/ud/busy/rdy/done/ab=%b sv=%0d want %b",
                         it, s, e, d, b, a, bad,
                         {tr_set[bad], tr_en[bad], tr_ud[bad], tr_busy[bad], tr_rdy[bad], tr_done[bad], tr_ab[bad]},
                         tr_sv[bad], m_vec(bad));
            end
            if (!m_abe) begin
                lo = 15; hi = 0;
                for (int c = 2; c <= m_done; c++) begin
                    if (int'(tr_cnt[c]) < lo) lo = int'(tr_cnt[c]);
                    if (int'(tr_cnt[c]) > hi) hi = int'(tr_cnt[c]);
                end
                n_tests++;
                if (int'(tr_cnt[2]) != s || int'(tr_cnt[m_done]) != ((b && m_n > 0) ? s : e)
                    || lo != ((s < e) ? s : e) || hi != ((s > e) ? s : e)) begin
                    n_fail++;
                    $display("FAIL rand%0d_count s=%0d e=%0d: got c2=%0d final=%0d min=%0d max=%0d",
                             it, s, e, tr_cnt[2], tr_cnt[m_done], lo, hi);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_start = '0; cmd_end = '0;
        cmd_div = '0; cmd_bounce = 1'b0; abort = 1'b0;
        test_reset();
        test_up_sweep();
        test_bounce_down();
        test_equal();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        test_random_sweeps();
        test_extreme();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer that drives the 4-bit up/down counter through programmed sweeps. A command loads a start value, steps the counter toward an end value at a programmable rate, optionally sweeps back to start, then reports done. The block sits between the command source (CPU or test logic) and the counter's set/set_value/enable/up_down pins. It reads the live counter output to detect arrival.

## Interface
- WIDTH, 4: counter width; must match the counter.
- DIV_W, 8: width of the step-interval field.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge; equals (state == IDLE).
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_end  in  WIDTH  sweep end value.
- cmd_div  in  DIV_W  D; one counter step every D+1 cycles.
- cmd_bounce  in  1  1: sweep start->end->start; 0: start->end only.
- abort  in  1  cancel the active command.
- ctr_set  out  1  to counter set.
- ctr_set_value  out  WIDTH  to counter set_value.
- ctr_enable  out  1  to counter enable.
- ctr_up_down  out  1  to counter up_down (1 = up).
- ctr_count  in  WIDTH  from counter count.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes normally.
- aborted  out  1  one-cycle pulse when a command is cancelled by abort.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DONE.
- Reset: state IDLE; done, aborted, ctr_set, ctr_enable, ctr_up_down, ctr_set_value all 0; latched fields cleared. Reset has priority over every other input; a handshake during reset is not accepted. The external counter is not touched by this block's reset.
- IDLE: cmd_ready=1. On accept, latch start, end, D, bounce. Latch dir = (cmd_end > cmd_start, unsigned). Set phase=0. Go to LOAD.
- LOAD: ctr_set=1, ctr_set_value=start for exactly one cycle. Prescaler <= D. Go to SETTLE.
- SETTLE: one cycle with no counter control while the counter register updates. Prescaler <= D. Go to RUN.
- RUN: target = end in phase 0 and start in phase 1. Counter direction is dir in phase 0 and !dir in phase 1, driven on ctr_up_down.
  - If ctr_count != target:
    - prescaler == 0: ctr_enable=1 (combinational) and prescaler <= D.
    - otherwise: prescaler decrements.
  - If ctr_count == target, ctr_enable=0, and:
    - phase 0, bounce=1 and start != end: phase <= 1, prescaler <= D, stay in RUN.
    - otherwise: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- ctr_up_down holds the current direction while busy and is 0 in IDLE. ctr_set_value is 0 outside LOAD.
- The direction is chosen so the counter never wraps.
- start == end: no enable is issued and bounce is ignored.
- Abort, in any state other than IDLE:
  - ctr_set and ctr_enable are forced to 0 in that cycle (combinational gate).
  - Next state is IDLE, and aborted pulses in that next cycle. done is not pulsed.
  - Abort in IDLE is ignored.
  - Abort and DONE in the same cycle: the done pulse stands and aborted stays 0.
- Arithmetic: prescaler is DIV_W bits unsigned. Comparisons are WIDTH-bit unsigned.
- Combinational path ctr_count -> ctr_enable is intended and prevents overshoot at D=0.

## Timing
- Cycle 0 is the accept edge's cycle. LOAD is cycle 1 and SETTLE is cycle 2, with ctr_count == start in SETTLE. RUN begins at cycle 3.
- N = |end - start|. In RUN phase 0, enables occur at RUN cycles D, 2D+1, …; ctr_count == end at RUN cycle N(D+1).
- Single sweep: done is high at absolute cycle N(D+1)+4; cmd_ready is high again at cycle N(D+1)+5.
- Bounce: one turnaround cycle. done is high at cycle 2N(D+1)+5.
- Back-to-back commands: the earliest next accept is the first IDLE cycle after done.

## Test plan
- Reset then idle: after reset, check cmd_ready=1 and busy=0. Check ctr_set, ctr_enable and done are 0.
- Up sweep, start=2, end=6, D=0, bounce=0 -> ctr_set pulse at cycle 1 with value 2. Enables at cycles 3-6, count 3,4,5,6. done at cycle 8.
- Down sweep with bounce, start=9, end=7, D=2 -> ctr_up_down=0 then 1. Count 9,8,7,8,9 with enables every 3rd cycle. done at cycle 2·2·3+5 = 17. No wrap occurs.
- start=end=5, D=4, bounce=1 -> no ctr_enable ever; done at cycle 4.
- Abort during RUN, start=0, end=15, D=1, abort at cycle 8 -> ctr_enable=0 in cycle 8. aborted=1 in cycle 9, done never asserts, cmd_ready=1 at cycle 9.
- Extremes and handshake: start=0, end=15, D=255 -> 15 enables spaced 256 cycles apart, done at cycle 3844. A cmd_valid held during busy is accepted only after done.
